mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 64, giving the data width (legal values 32, 64).
REQ-002 The block SHALL have parameter ADDR_W, default 64, giving the address width.
REQ-003 The block SHALL have parameter STRB_W, default XLEN/8, giving the byte-strobe width.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: pipeline access request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-008 The block SHALL have port req_op, input, 4 bits: bit3 = store; bit2 = zero-extend (loads only); bits1:0 = size (0 byte, 1 half, 2 word, 3 double).
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, XLEN bits: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the pipeline takes the result.
REQ-013 The block SHALL have port rsp_data, output, XLEN bits: extended load data (0 for stores).
REQ-014 The block SHALL have port rsp_err, output, 1 bit: misaligned or illegal access.
REQ-015 The block SHALL have the following memory-side ports:
- mem_req_valid, output, 1 bit
- mem_req_ready, input, 1 bit
- mem_addr, output, ADDR_W bits: aligned to STRB_W
- mem_wen, output, 1 bit
- mem_wdata, output, XLEN bits: lane-shifted
- mem_wstrb, output, STRB_W bits
- mem_rsp_valid, input, 1 bit
- mem_rdata, input, XLEN bits

Function
REQ-016 The block SHALL implement FSM states IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 On req_valid&&req_ready the block SHALL register op, addr and wdata, and compute offset = addr mod STRB_W.
REQ-018 Access SHALL be misaligned when offset is not a multiple of 2^size, or size = 3 with XLEN = 32.
REQ-019 On a misaligned request the block SHALL go IDLE->RESP with rsp_err = 1 and rsp_data = 0, with no memory access.
REQ-020 On an aligned request the block SHALL go IDLE->REQ, driving the memory-side request signals.
REQ-021 In REQ the block SHALL drive:
- mem_req_valid = 1
- mem_addr = addr with its low log2(STRB_W) bits cleared
- mem_wen = op[3]
REQ-022 For stores the block SHALL set mem_wstrb to (2^size ones) << offset; for loads mem_wstrb SHALL be all ones.
REQ-023 For stores the block SHALL set mem_wdata = wdata << (8*offset), truncated to XLEN.
REQ-024 All mem_* outputs SHALL remain stable until mem_req_ready = 1 is sampled; then the block SHALL go to WAIT.
REQ-025 In WAIT the block SHALL hold until mem_rsp_valid = 1; mem_rsp_valid in the same cycle as the REQ->WAIT handshake SHALL be ignored.
REQ-026 In WAIT, when mem_rsp_valid = 1, the block SHALL capture rsp_data and go to RESP:
- loads: (mem_rdata >> 8*offset), keep low 8*2^size bits, then sign-extend (op[2] = 0) or zero-extend (op[2] = 1)
- stores: 0
REQ-027 In RESP the block SHALL hold rsp_valid = 1 and rsp_data/rsp_err stable until rsp_ready = 1, then go to IDLE.
REQ-028 Load-to-response latency SHALL be 3 cycles minimum from the accept edge (REQ, WAIT, RESP), with zero-wait memory.
REQ-029 A new request SHALL be accepted no earlier than the cycle after the RESP handshake, so at most one access is outstanding.
REQ-030 op[2] set on a store, and size = 3 zero-extend with XLEN = 64, SHALL be accepted and SHALL have no effect.

Reset
REQ-031 When rst_n = 0 the block SHALL immediately go to IDLE, asynchronously and regardless of current state, including mid-access.
REQ-032 During reset the block SHALL drive:
- req_ready = 0
- rsp_valid = 0, rsp_data = 0, rsp_err = 0
- all mem_* outputs = 0
REQ-033 req_ready SHALL go to 1 on the first clk edge after rst_n deasserts, and no memory response SHALL be tracked across reset.

Verification
REQ-034 The bench SHALL cover a signed byte load: LB addr 0x1003 with mem_rdata 0x11223344_80667788 -> mem_addr 0x1000, rsp_data 0xFFFFFFFF_FFFFFF80, rsp_err 0.
REQ-035 The bench SHALL cover an unsigned word load: LWU addr 0x2004 with mem_rdata 0xDEADBEEF_00000000 -> rsp_data 0x00000000_DEADBEEF.
REQ-036 The bench SHALL cover a halfword store: SH addr 0x3006, wdata 0xABCD -> mem_wstrb 0xC0, mem_wdata 0xABCD0000_00000000, mem_wen 1, rsp_data 0.
REQ-037 The bench SHALL cover a misaligned access: LW addr 0x4002 -> rsp_valid one cycle after accept, rsp_err 1, mem_req_valid never asserted.
REQ-038 The bench SHALL cover backpressure: mem_req_ready held 0 for 5 cycles, then rsp_ready held 0 for 3 cycles -> mem_* outputs stable throughout, rsp_valid held, single handshake each side.
REQ-039 The bench SHALL cover reset mid-access: rst_n pulsed low in WAIT -> all outputs 0 at once, req_ready 1 after release, stale mem_rsp_valid ignored.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit between the pipeline and a
// single-beat memory port. Aligns stores into byte lanes and extends loads.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_* (valid/ready)  pipeline access: op, byte address, right-aligned data
//   rsp_* (valid/ready)  extended load data (0 for stores), error flag
//   mem_req_* / mem_*    lane-aligned memory request and load return
module mem_lsu #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              armed;
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   data;
    logic              err;

    logic              accept;
    logic              in_req;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  align_mask;
    logic              misaligned;
    logic [STRB_W-1:0] size_strb;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   keep;
    logic              sign;
    logic [XLEN-1:0]   load_val;

    assign accept  = req_valid && req_ready;
    assign in_req  = (state == REQ);
    assign req_off = req_addr[OFF_W-1:0];
    assign off     = addr[OFF_W-1:0];

    // Low offset bits that must be clear for a naturally aligned access.
    assign align_mask = OFF_W'((4'd1 << req_op[1:0]) - 4'd1);
    assign misaligned = (|(req_off & align_mask))
                     || ((req_op[1:0] == 2'd3) && (XLEN == 32));

    always_comb begin
        size_strb = '1;
        unique case (op[1:0])
            2'd0:    size_strb = STRB_W'(8'h01);
            2'd1:    size_strb = STRB_W'(8'h03);
            2'd2:    size_strb = STRB_W'(8'h0F);
            default: size_strb = '1;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then keep only
    // the access width and fill the rest with sign or zero.
    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        keep = '1;
        sign = shifted[XLEN-1];
        unique case (op[1:0])
            2'd0: begin
                keep = XLEN'(8'hFF);
                sign = shifted[7];
            end
            2'd1: begin
                keep = XLEN'(16'hFFFF);
                sign = shifted[15];
            end
            2'd2: begin
                keep = XLEN'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                keep = '1;
                sign = shifted[XLEN-1];
            end
        endcase
    end

    assign load_val = (shifted & keep)
                    | ((sign && !op[2]) ? ~keep : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // armed keeps req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            op    <= '0;
            addr  <= '0;
            wdata <= '0;
            data  <= '0;
            err   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                op    <= req_op;
                addr  <= req_addr;
                wdata <= req_wdata;
                data  <= '0;
                err   <= misaligned;
            end
            if ((state == WAIT) && mem_rsp_valid) begin
                data <= op[3] ? '0 : load_val;
            end
        end
    end

    assign req_ready = armed && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = data;
    assign rsp_err   = err;

    // Memory outputs come straight from registered request state, so they
    // stay stable for as long as REQ is held.
    assign mem_req_valid = in_req;
    assign mem_addr      = in_req ? {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wen       = in_req && op[3];
    assign mem_wdata     = (in_req && op[3]) ? (wdata << {off, 3'b000}) : '0;
    assign mem_wstrb     = !in_req ? '0
                         : (op[3] ? (size_strb << off) : '1);

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with directed access vectors.
// Stimulus queues expectations; memory model and response monitor check.
module tb_mem_lsu;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        bit          junk;
        bit          hold;
    } mreq_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_stall = 0;
    int rsp_stall = 0;
    bit force_rsp = 0;

    rsp_t  rq[$];
    mreq_t mq[$];

    mem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({name, "_flags"},
            64'({rsp_valid, rsp_err, mem_req_valid, mem_wen}), 64'd0);
        chk({name, "_rsp_data"}, rsp_data, 64'd0);
        chk({name, "_mem_addr"}, mem_addr, 64'd0);
        chk({name, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({name, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    endtask

    // Memory-side model: checks request contents and stability, applies
    // request backpressure, returns load data one cycle after the grant.
    initial begin : mem_model
        bit          pend;
        bit          mseen;
        bit          after_hs;
        logic [63:0] pend_data;
        logic [136:0] snap;
        mreq_t       m;
        pend = 0;
        mseen = 0;
        after_hs = 0;
        pend_data = '0;
        snap = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (after_hs) begin
                chk("mem_single_handshake", 64'(mem_req_valid), 64'd0);
                after_hs = 0;
            end
            mem_rsp_valid = force_rsp;
            if (force_rsp) mem_rdata = 64'hBADB_ADBA_DBAD_BADB;
            if (pend) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = pend_data;
                pend = 0;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req: got addr %h expected none",
                             mem_addr);
                    mem_req_ready = 1'b1;
                end else begin
                    m = mq[0];
                    if (!mseen) begin
                        mseen = 1;
                        snap = {mem_addr, mem_wen, mem_wdata, mem_wstrb};
                    end else begin
                        checks++;
                        if ({mem_addr, mem_wen, mem_wdata, mem_wstrb} !== snap) begin
                            errors++;
                            $display("FAIL mem_stable: got addr %h wdata %h expected addr %h wdata %h",
                                     mem_addr, mem_wdata, snap[136:73], snap[71:8]);
                        end
                    end
                    if (mem_stall > 0) begin
                        mem_stall--;
                    end else begin
                        mem_req_ready = 1'b1;
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_wen", 64'(mem_wen), 64'(m.wen));
                        chk("mem_wstrb", 64'(mem_wstrb), 64'(m.wstrb));
                        if (m.wen) chk("mem_wdata", mem_wdata, m.wdata);
                        void'(mq.pop_front());
                        mseen = 0;
                        after_hs = 1;
                        if (m.junk) begin
                            mem_rsp_valid = 1'b1;
                            mem_rdata = ~m.rdata;
                        end
                        if (!m.hold) begin
                            pend = 1;
                            pend_data = m.rdata;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: drives rsp_ready, checks latency, hold and data.
    initial begin : rsp_monitor
        bit          seen;
        bit          after_hs;
        logic [63:0] snap_d;
        logic        snap_e;
        rsp_t        r;
        seen = 0;
        after_hs = 0;
        snap_d = '0;
        snap_e = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (after_hs) begin
                chk("rsp_single_handshake", 64'(rsp_valid), 64'd0);
                after_hs = 0;
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %h err %b expected none",
                             rsp_data, rsp_err);
                    rsp_ready = 1'b1;
                end else begin
                    r = rq[0];
                    if (!seen) begin
                        seen = 1;
                        snap_d = rsp_data;
                        snap_e = rsp_err;
                        if (r.lat > 0)
                            chk("rsp_latency", 64'(cyc - r.acc + 1), 64'(r.lat));
                    end else begin
                        chk("rsp_stable", {rsp_data[62:0], rsp_err},
                            {snap_d[62:0], snap_e});
                    end
                    if (rsp_stall > 0) begin
                        rsp_stall--;
                    end else begin
                        rsp_ready = 1'b1;
                        chk("rsp_data", rsp_data, r.data);
                        chk("rsp_err", 64'(rsp_err), 64'(r.err));
                        void'(rq.pop_front());
                        seen = 0;
                        after_hs = 1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit has_mem,
                         input mreq_t m, input bit has_rsp, input rsp_t r);
        int budget;
        budget = 100;
        @(negedge clk);
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1");
            return;
        end
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_wdata = wdata;
        r.acc = cyc + 1;
        if (has_mem) mq.push_back(m);
        if (has_rsp) rq.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = '0;
        req_addr = '0;
        req_wdata = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        mreq_t mz;
        int    budget;
        mz = '{64'd0, 1'b0, 64'd0, 8'd0, 64'd0, 1'b0, 1'b0};
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_addr = '0;
        req_wdata = '0;
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        #19 rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(req_ready), 64'd1);

        // LB 0x1003
        issue(4'b0000, 64'h1003, 64'd0,
              1, '{64'h1000, 1'b0, 64'd0, 8'hFF, 64'h11223344_80667788, 1'b0, 1'b0},
              1, '{64'hFFFFFFFF_FFFFFF80, 1'b0, 0, 3});
        // LWU 0x2004, junk mem_rsp_valid on the request handshake
        issue(4'b0110, 64'h2004, 64'd0,
              1, '{64'h2000, 1'b0, 64'd0, 8'hFF, 64'hDEADBEEF_00000000, 1'b1, 1'b0},
              1, '{64'h00000000_DEADBEEF, 1'b0, 0, 3});
        // SH 0x3006
        issue(4'b1001, 64'h3006, 64'hABCD,
              1, '{64'h3000, 1'b1, 64'hABCD0000_00000000, 8'hC0, 64'hFFFF, 1'b0, 1'b0},
              1, '{64'd0, 1'b0, 0, 3});
        // LW 0x4002 misaligned
        issue(4'b0010, 64'h4002, 64'd0, 0, mz,
              1, '{64'd0, 1'b1, 0, 1});
        // LD 0x5008
        issue(4'b0011, 64'h5008, 64'd0,
              1, '{64'h5008, 1'b0, 64'd0, 8'hFF, 64'h81234567_89ABCDEF, 1'b0, 1'b0},
              1, '{64'h81234567_89ABCDEF, 1'b0, 0, 3});
        // LH 0x5006 top half, negative
        issue(4'b0001, 64'h5006, 64'd0,
              1, '{64'h5000, 1'b0, 64'd0, 8'hFF, 64'h80000000_00000000, 1'b0, 1'b0},
              1, '{64'hFFFFFFFF_FFFF8000, 1'b0, 0, 3});
        // LHU 0x5002
        issue(4'b0101, 64'h5002, 64'd0,
              1, '{64'h5000, 1'b0, 64'd0, 8'hFF, 64'h00000000_F00D0000, 1'b0, 1'b0},
              1, '{64'h00000000_0000F00D, 1'b0, 0, 3});
        // SD with op[2] set: no effect
        issue(4'b1111, 64'h6000, 64'h01234567_89ABCDEF,
              1, '{64'h6000, 1'b1, 64'h01234567_89ABCDEF, 8'hFF, 64'd0, 1'b0, 1'b0},
              1, '{64'd0, 1'b0, 0, 3});
        // SB 0x6005: whole wdata shifted and truncated
        issue(4'b1000, 64'h6005, 64'hFFFFFFFF_FFFFFF5A,
              1, '{64'h6000, 1'b1, 64'hFFFF5A00_00000000, 8'h20, 64'd0, 1'b0, 1'b0},
              1, '{64'd0, 1'b0, 0, 3});
        // LD zero-extend: no effect
        issue(4'b0111, 64'h7000, 64'd0,
              1, '{64'h7000, 1'b0, 64'd0, 8'hFF, 64'hFEDCBA98_76543210, 1'b0, 1'b0},
              1, '{64'hFEDCBA98_76543210, 1'b0, 0, 3});
        // LD 0x7004 misaligned
        issue(4'b0011, 64'h7004, 64'd0, 0, mz,
              1, '{64'd0, 1'b1, 0, 1});
        // LH 0x8001 misaligned
        issue(4'b0001, 64'h8001, 64'd0, 0, mz,
              1, '{64'd0, 1'b1, 0, 1});

        // Backpressure on both sides
        mem_stall = 5;
        rsp_stall = 3;
        issue(4'b0010, 64'h8004, 64'd0,
              1, '{64'h8000, 1'b0, 64'd0, 8'hFF, 64'h89ABCDEF_00000000, 1'b0, 1'b0},
              1, '{64'hFFFFFFFF_89ABCDEF, 1'b0, 0, 0});

        // Reset while waiting for the memory response
        issue(4'b0011, 64'hA000, 64'd0,
              1, '{64'hA000, 1'b0, 64'd0, 8'hFF, 64'h12345678_9ABCDEF0, 1'b0, 1'b1},
              0, '{64'd0, 1'b0, 0, 0});
        @(negedge clk);
        #1 rst_n = 1'b0;
        force_rsp = 1'b1;
        #1 check_zero("reset_mid");
        #1 rst_n = 1'b1;
        #1 chk("mid_ready_before_edge", 64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_ready_after", 64'(req_ready), 64'd1);
            chk("mid_stale_ignored", 64'({rsp_valid, mem_req_valid}), 64'd0);
        end
        force_rsp = 1'b0;

        // LBU 0x9001 after reset
        issue(4'b0100, 64'h9001, 64'd0,
              1, '{64'h9000, 1'b0, 64'd0, 8'hFF, 64'h00000000_0000AB00, 1'b0, 1'b0},
              1, '{64'h00000000_000000AB, 1'b0, 0, 3});

        budget = 100;
        while ((rq.size() != 0 || mq.size() != 0 || !req_ready) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain_rsp_queue", 64'(rq.size()), 64'd0);
        chk("drain_mem_queue", 64'(mq.size()), 64'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
